// File: rtl/controle_fechadura_pkg.sv
// Shared types and constants for the PIN door-lock controller.
// PIN packets carry four BCD keys plus a one-cycle submit strobe.
package controle_fechadura_pkg;

  localparam logic [3:0] DIGIT_BLANK = 4'hE;
  localparam logic [3:0] KEY_SEND    = 4'hF;

  typedef struct packed {
    logic       status;
    logic [3:0] digit4;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
  } pinPac_t;

  typedef logic [15:0] senha_t;

  // digit4 holds the first key entered, digit1 the most recent
  localparam senha_t DEFAULT_PIN = 16'h1234;

  typedef enum logic [1:0] {
    TRANCADO,
    ABERTO,
    CONFIG,
    BLOQUEIO
  } estado_t;

  function automatic logic digito_valido(input logic [3:0] d);
    return (d != DIGIT_BLANK) && (d <= 4'd9);
  endfunction

  function automatic logic pin_completo(input pinPac_t p);
    return digito_valido(p.digit4) && digito_valido(p.digit3) &&
           digito_valido(p.digit2) && digito_valido(p.digit1);
  endfunction

  function automatic senha_t pin_digitos(input pinPac_t p);
    return {p.digit4, p.digit3, p.digit2, p.digit1};
  endfunction

endpackage

// File: rtl/temporizador.sv
// Loadable down-counter shared by all timed lock states.
// A load of N-1 makes o_fim rise after exactly N counting cycles.
module temporizador #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_carga,
  input  logic [WIDTH-1:0] i_valor,
  output logic             o_fim
);

  logic [WIDTH-1:0] r_contagem;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_contagem <= '0;
    end else if (i_carga) begin
      r_contagem <= i_valor;
    end else if (r_contagem != '0) begin
      r_contagem <= r_contagem - 1'b1;
    end
  end

  assign o_fim = (r_contagem == '0);

endmodule

// File: rtl/controle_fechadura.sv
// PIN door-lock controller: unlock window, password change mode and
// lockout after repeated failures. All outputs are registered.
module controle_fechadura
  import controle_fechadura_pkg::*;
#(
  parameter int unsigned UNLOCK_CYCLES  = 250,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned CONFIG_CYCLES  = 500,
  parameter int unsigned MAX_ATTEMPTS   = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  pinPac_t pin_in,
  input  logic    btn_config,
  output logic    tranca_aberta,
  output logic    bloqueado,
  output logic    modo_config,
  output logic    erro,
  output logic [2:0] tentativas
);

  localparam int unsigned MaxCiclos =
      (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
      ((UNLOCK_CYCLES > CONFIG_CYCLES) ? UNLOCK_CYCLES : CONFIG_CYCLES) :
      ((LOCKOUT_CYCLES > CONFIG_CYCLES) ? LOCKOUT_CYCLES : CONFIG_CYCLES);
  localparam int unsigned TimerW = $clog2(MaxCiclos + 1);

  localparam logic [TimerW-1:0] CargaAberto   = TimerW'(UNLOCK_CYCLES - 1);
  localparam logic [TimerW-1:0] CargaBloqueio = TimerW'(LOCKOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] CargaConfig   = TimerW'(CONFIG_CYCLES - 1);
  localparam logic [2:0]        MaxTent       = 3'(MAX_ATTEMPTS);

  estado_t           r_estado;
  estado_t           w_estado_prox;
  senha_t            r_senha;
  senha_t            w_senha_prox;
  logic [2:0]        r_tentativas;
  logic [2:0]        w_tentativas_prox;
  logic [2:0]        w_tent_inc;
  logic              r_tranca;
  logic              r_bloqueado;
  logic              r_modo_config;
  logic              r_erro;
  logic              w_erro_prox;
  logic              w_carga;
  logic [TimerW-1:0] w_valor;
  logic              w_fim;
  logic              w_completo;
  logic              w_confere;

  assign w_completo = pin_completo(pin_in);
  assign w_confere  = (pin_digitos(pin_in) == r_senha);
  assign w_tent_inc = r_tentativas + 3'd1;

  temporizador #(
    .WIDTH(TimerW)
  ) u_temporizador (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_carga(w_carga),
    .i_valor(w_valor),
    .o_fim  (w_fim)
  );

  always_comb begin
    w_estado_prox     = r_estado;
    w_senha_prox      = r_senha;
    w_tentativas_prox = r_tentativas;
    w_erro_prox       = 1'b0;
    w_carga           = 1'b0;
    w_valor           = '0;
    unique case (r_estado)
      TRANCADO: begin
        if (pin_in.status) begin
          if (w_completo && w_confere) begin
            w_estado_prox     = ABERTO;
            w_tentativas_prox = 3'd0;
            w_carga           = 1'b1;
            w_valor           = CargaAberto;
          end else begin
            w_erro_prox       = 1'b1;
            w_tentativas_prox = w_tent_inc;
            if (w_tent_inc >= MaxTent) begin
              w_estado_prox = BLOQUEIO;
              w_carga       = 1'b1;
              w_valor       = CargaBloqueio;
            end
          end
        end
      end
      ABERTO: begin
        // Expiry takes priority over a simultaneous config request
        if (w_fim) begin
          w_estado_prox = TRANCADO;
        end else if (btn_config) begin
          w_estado_prox = CONFIG;
          w_carga       = 1'b1;
          w_valor       = CargaConfig;
        end
      end
      CONFIG: begin
        if (pin_in.status) begin
          w_estado_prox = TRANCADO;
          if (w_completo) begin
            w_senha_prox = pin_digitos(pin_in);
          end else begin
            w_erro_prox = 1'b1;
          end
        end else if (w_fim) begin
          w_estado_prox = TRANCADO;
        end
      end
      BLOQUEIO: begin
        if (w_fim) begin
          w_estado_prox     = TRANCADO;
          w_tentativas_prox = 3'd0;
        end
      end
      default: w_estado_prox = TRANCADO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado      <= TRANCADO;
      r_senha       <= DEFAULT_PIN;
      r_tentativas  <= 3'd0;
      r_tranca      <= 1'b0;
      r_bloqueado   <= 1'b0;
      r_modo_config <= 1'b0;
      r_erro        <= 1'b0;
    end else begin
      r_estado      <= w_estado_prox;
      r_senha       <= w_senha_prox;
      r_tentativas  <= w_tentativas_prox;
      r_tranca      <= (w_estado_prox == ABERTO) || (w_estado_prox == CONFIG);
      r_bloqueado   <= (w_estado_prox == BLOQUEIO);
      r_modo_config <= (w_estado_prox == CONFIG);
      r_erro        <= w_erro_prox;
    end
  end

  assign tranca_aberta = r_tranca;
  assign bloqueado     = r_bloqueado;
  assign modo_config   = r_modo_config;
  assign erro          = r_erro;
  assign tentativas    = r_tentativas;

endmodule

// File: tb/tb_controle_fechadura.sv
// Scoreboard bench for controle_fechadura: expected output vectors
// {tranca, bloqueado, modo_config, erro, tentativas} are queued then checked.
module tb_controle_fechadura;
  import controle_fechadura_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  pinPac_t    pin_in = '0;
  logic       btn_config = 1'b0;
  logic       tranca_aberta;
  logic       bloqueado;
  logic       modo_config;
  logic       erro;
  logic [2:0] tentativas;

  localparam logic [6:0] VOpen   = 7'b1000000;
  localparam logic [6:0] VClosed = 7'b0000000;
  localparam logic [6:0] VCfg    = 7'b1010000;

  logic [6:0] sb[$];
  logic [6:0] got;
  logic [6:0] exp_v;
  int n_checks = 0;
  int n_errors = 0;

  controle_fechadura dut (
    .clk          (clk),
    .rst          (rst),
    .pin_in       (pin_in),
    .btn_config   (btn_config),
    .tranca_aberta(tranca_aberta),
    .bloqueado    (bloqueado),
    .modo_config  (modo_config),
    .erro         (erro),
    .tentativas   (tentativas)
  );

  always #5 clk = ~clk;

  function automatic pinPac_t mk(input logic s, input logic [3:0] a, input logic [3:0] b,
                                 input logic [3:0] c, input logic [3:0] d);
    pinPac_t p;
    p.status = s;
    p.digit4 = a;
    p.digit3 = b;
    p.digit2 = c;
    p.digit1 = d;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    pin_in.status = 1'b0;
    btn_config    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Reset wins over a simultaneous correct submit
    pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    rst = 1'b1;
    sb.push_back(VClosed);
    sb.push_back(VClosed);
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL reset[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_open();
    do_reset();
    pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    repeat (250) sb.push_back(VOpen);
    sb.push_back(VClosed);
    for (int i = 0; i < 251; i++) begin
      if (i == 10) pin_in = mk(1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL open[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_lockout();
    do_reset();
    sb.push_back(7'b0001001);
    sb.push_back(7'b0000001);
    sb.push_back(7'b0001010);
    sb.push_back(7'b0000010);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) pin_in = mk(1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL fail_count[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
    pin_in = mk(1'b1, 4'd9, 4'd9, 4'd9, 4'd9);
    sb.push_back(7'b0101011);
    repeat (999) sb.push_back(7'b0100011);
    sb.push_back(VClosed);
    sb.push_back(VOpen);
    for (int i = 0; i < 1002; i++) begin
      if (i == 500 || i == 1001) begin
        pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        btn_config = 1'b1;
      end
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL lockout[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_incomplete();
    do_reset();
    sb.push_back(7'b0001001);
    sb.push_back(7'b0000001);
    sb.push_back(7'b0001010);
    sb.push_back(7'b0000010);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) pin_in = mk(1'b1, DIGIT_BLANK, DIGIT_BLANK, 4'd3, 4'd4);
      if (i == 1) btn_config = 1'b1;
      if (i == 2) pin_in = mk(1'b1, 4'hA, 4'd1, 4'd2, 4'd3);
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL incomplete[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sb.push_back(7'b0001001);
    sb.push_back(7'b0001010);
    sb.push_back(VOpen);
    for (int i = 0; i < 3; i++) begin
      if (i < 2) pin_in = mk(1'b1, 4'd4, 4'd3, 4'd2, 4'd1);
      else       pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL back_to_back[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_config_change();
    do_reset();
    sb.push_back(VOpen);
    sb.push_back(VCfg);
    sb.push_back(VCfg);
    sb.push_back(VClosed);
    sb.push_back(7'b0001001);
    sb.push_back(VOpen);
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        1: btn_config = 1'b1;
        3: pin_in = mk(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
        4: pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        5: pin_in = mk(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
        default: ;
      endcase
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL config_change[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_config_invalid();
    do_reset();
    sb.push_back(VOpen);
    sb.push_back(VCfg);
    sb.push_back(7'b0001000);
    sb.push_back(VOpen);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        1: btn_config = 1'b1;
        2: pin_in = mk(1'b1, DIGIT_BLANK, 4'd6, 4'd7, 4'd8);
        3: pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        default: ;
      endcase
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL config_invalid[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_config_timeout();
    do_reset();
    sb.push_back(VOpen);
    repeat (500) sb.push_back(VCfg);
    sb.push_back(VClosed);
    sb.push_back(VOpen);
    for (int i = 0; i < 503; i++) begin
      if (i == 0 || i == 502) pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
      if (i == 1) btn_config = 1'b1;
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL config_timeout[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_expiry_vs_config();
    do_reset();
    repeat (250) sb.push_back(VOpen);
    sb.push_back(VClosed);
    sb.push_back(VClosed);
    for (int i = 0; i < 252; i++) begin
      if (i == 0) pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
      if (i == 250 || i == 251) btn_config = 1'b1;
      tick();
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL expiry_vs_config[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    // Change password to 5678, open with it, reset on cycle 100 of ABERTO
    pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    tick();
    btn_config = 1'b1;
    tick();
    pin_in = mk(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
    tick();
    pin_in = mk(1'b1, 4'd5, 4'd6, 4'd7, 4'd8);
    repeat (100) sb.push_back(VOpen);
    sb.push_back(VClosed);
    sb.push_back(VOpen);
    for (int i = 0; i < 102; i++) begin
      if (i == 100) rst = 1'b1;
      if (i == 101) pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
      tick();
      rst = 1'b0;
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL reset_mid_open[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
    // Reset during lockout and during config
    do_reset();
    sb.push_back(7'b0001001);
    sb.push_back(7'b0001010);
    sb.push_back(7'b0101011);
    sb.push_back(VClosed);
    sb.push_back(VOpen);
    sb.push_back(VCfg);
    sb.push_back(VClosed);
    sb.push_back(VOpen);
    for (int i = 0; i < 8; i++) begin
      if (i < 3) pin_in = mk(1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
      if (i == 3 || i == 6) rst = 1'b1;
      if (i == 4 || i == 7) pin_in = mk(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
      if (i == 5) btn_config = 1'b1;
      tick();
      rst = 1'b0;
      got = {tranca_aberta, bloqueado, modo_config, erro, tentativas};
      exp_v = sb.pop_front();
      n_checks++;
      if (got !== exp_v) begin
        n_errors++;
        $display("FAIL reset_mid_other[%0d] got=%b exp=%b", i, got, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_open();
    test_lockout();
    test_incomplete();
    test_back_to_back();
    test_config_change();
    test_config_invalid();
    test_config_timeout();
    test_expiry_vs_config();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
